rf_wr_arbiter: RTL and testbench
================================

Name: rf_wr_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: ALU (A) and load/memory (M).
- Each requester gets a one-entry holding slot with a valid/ready handshake.
- A round-robin arbiter issues one registered write per cycle to the RF port (wr, wd, regwr).
- A combinational hazard output flags reads (rr1/rr2) that hit a write still in flight, so the decode stage can stall.

Parameters:
- DW, 32, data width (matches RF word).
- AW, 5, register address width (32 registers).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- a_valid  in  1  ALU write request valid.
- a_ready  out  1  ALU slot can accept.
- a_addr  in  AW  ALU destination register.
- a_data  in  DW  ALU write data.
- m_valid  in  1  load write request valid.
- m_ready  out  1  load slot can accept.
- m_addr  in  AW  load destination register.
- m_data  in  DW  load write data.
- wr  out  AW  RF write address (registered).
- wd  out  DW  RF write data (registered).
- regwr  out  1  RF write enable (registered, one cycle per write).
- rr1  in  AW  decode read address 1.
- rr2  in  AW  decode read address 2.
- hazard  out  1  rr1 or rr2 matches a pending write.

Behaviour:
- Reset: clk edge with rst_n=0 clears both slots, regwr=0, wr=0, wd=0, rr_ptr=A. Pending writes are dropped, including on reset mid-operation.
- Slots: each slot holds {valid, addr, data}.
  - x_ready = !slot_x.valid || grant_x. grant_x is derived from slot state only; there is no valid-to-ready combinational path.
  - Accept = x_valid && x_ready. The slot loads at that edge.
- Arbitration, combinational from slot valids and rr_ptr:
  - Both valid: grant the slot rr_ptr points to, then rr_ptr flips to the other requester.
  - One valid: grant it, and rr_ptr points to the other requester.
  - None valid: no grant, rr_ptr holds.
- Issue: on a grant edge, {wr, wd} load from the granted slot and regwr=1 for exactly the following cycle. The granted slot empties unless refilled at the same edge.
  - With no grant: regwr=0 and wr/wd hold their last values.
- Latency: accept at edge N, issue at edge N+1 (regwr high in cycle N+1), RF commits at edge N+2.
- Throughput: one RF write per cycle. Each requester sustains one accept per cycle when it alone is active, and one every two cycles under contention.
- hazard = (slot_a.valid && slot_a.addr∈{rr1,rr2}) || (slot_m.valid && slot_m.addr∈{rr1,rr2}) || (regwr && wr∈{rr1,rr2}).
- Same-address writes from A and M in the same cycle: both are accepted and issued in arbitration order. The last issued value wins in the RF. No further ordering is guaranteed across requesters.
- Writes from a single requester issue in acceptance order.

Optional Feature:
- Macro: RF_ZERO_REG_GUARD_EN.
- Defined:
  - Requests with addr==0 are handshaken normally (ready as above) but discarded: the slot is not loaded and regwr never asserts for register 0.
  - hazard ignores rr1/rr2==0.
- Undefined: register 0 is treated like any other address.

Decomposition:
- Package rf_pkg:
  - RF_AW=5 and RF_DW=32.
  - Constants REQ_A=0 and REQ_M=1.
  - Typedef rf_wreq_t {logic valid; logic [RF_AW-1:0] addr; logic [RF_DW-1:0] data}.
- Sub-module rf_wr_slot: one-entry holding register with ready/accept/pop logic. It is instantiated twice, for A and M.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with a_valid=1 → regwr=0, wr=0, wd=0, a_ready=m_ready=1 after release. No write issues from the pre-reset request.
- Single ALU write: a_valid=1, a_addr=4, a_data=0x0123 for one cycle → regwr=1 with wr=4, wd=0x0123 exactly one cycle later. hazard=1 for rr1=4 during the slot and issue cycles, 0 afterwards.
- Contention: A{3,0xAAAA} and M{5,0xBBBB} valid at the same edge, rr_ptr=A → issues A then M on consecutive cycles. m_ready=0 for one cycle. Repeat → M issues first.
- Back-to-back ALU stream: 8 consecutive writes to regs 1..8 with m_valid=0 → a_ready stays 1 and regwr stays high for 8 consecutive cycles in order.
- Same-address race: A{7,0x1} and M{7,0x2} simultaneously, rr_ptr=A → final issued wd=0x2 for wr=7. hazard held until the last issue.
- Guard: with RF_ZERO_REG_GUARD_EN, a_addr=0 → a_ready=1 and regwr never asserts. Without the macro → regwr=1 with wr=0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write arbiter.
// Optional feature macro: RF_ZERO_REG_GUARD_EN (used by rf_wr_slot and rf_wr_arbiter).
package rf_pkg;

  localparam int RF_AW = 5;
  localparam int RF_DW = 32;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_M = 1'b1;

  typedef struct packed {
    logic             valid;
    logic [RF_AW-1:0] addr;
    logic [RF_DW-1:0] data;
  } rf_wreq_t;

endpackage

// File: rtl/rf_wr_slot.sv
// One-entry write-request holding slot with valid/ready intake and pop on grant.
// Optional feature macro: RF_ZERO_REG_GUARD_EN (discards requests to register 0).
module rf_wr_slot
  import rf_pkg::*;
#(
  parameter int AW = RF_AW,
  parameter int DW = RF_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_data,
  input  logic          pop,
  output logic          slot_valid,
  output logic [AW-1:0] slot_addr,
  output logic [DW-1:0] slot_data
);

  logic          valid_q, valid_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          accept;
  logic          load;

  // Handshake: a transfer happens on a clock edge where in_valid && in_ready.
  // in_ready depends only on slot state (pop comes from slot valids), never on in_valid.
  assign in_ready = !valid_q || pop;
  assign accept   = in_valid && in_ready;

`ifdef RF_ZERO_REG_GUARD_EN
  assign load = accept && (in_addr != '0);
`else
  assign load = accept;
`endif

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      addr_d  = in_addr;
      data_d  = in_data;
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign slot_valid = valid_q;
  assign slot_addr  = addr_q;
  assign slot_data  = data_q;

endmodule

// File: rtl/rf_wr_arbiter.sv
// Round-robin arbiter sharing the RF write port between ALU (A) and load (M) writeback.
// Optional feature macro: RF_ZERO_REG_GUARD_EN (register 0 writes dropped, rr==0 never hazards).
module rf_wr_arbiter
  import rf_pkg::*;
#(
  parameter int DW = RF_DW,
  parameter int AW = RF_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  input  logic          m_valid,
  output logic          m_ready,
  input  logic [AW-1:0] m_addr,
  input  logic [DW-1:0] m_data,
  output logic [AW-1:0] wr,
  output logic [DW-1:0] wd,
  output logic          regwr,
  input  logic [AW-1:0] rr1,
  input  logic [AW-1:0] rr2,
  output logic          hazard
);

  logic          sa_valid, sm_valid;
  logic [AW-1:0] sa_addr, sm_addr;
  logic [DW-1:0] sa_data, sm_data;
  logic          grant_a, grant_m;
  logic          rr_ptr_q, rr_ptr_d;
  logic          regwr_q;
  logic [AW-1:0] wr_q;
  logic [DW-1:0] wd_q;

  rf_wr_slot #(.AW(AW), .DW(DW)) u_slot_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (a_valid),
    .in_ready   (a_ready),
    .in_addr    (a_addr),
    .in_data    (a_data),
    .pop        (grant_a),
    .slot_valid (sa_valid),
    .slot_addr  (sa_addr),
    .slot_data  (sa_data)
  );

  rf_wr_slot #(.AW(AW), .DW(DW)) u_slot_m (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (m_valid),
    .in_ready   (m_ready),
    .in_addr    (m_addr),
    .in_data    (m_data),
    .pop        (grant_m),
    .slot_valid (sm_valid),
    .slot_addr  (sm_addr),
    .slot_data  (sm_data)
  );

  // rr_ptr only decides ties; after any grant it points at the other requester.
  assign grant_a = sa_valid && (!sm_valid || rr_ptr_q == REQ_A);
  assign grant_m = sm_valid && (!sa_valid || rr_ptr_q == REQ_M);

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_a)      rr_ptr_d = REQ_M;
    else if (grant_m) rr_ptr_d = REQ_A;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q <= REQ_A;
      regwr_q  <= 1'b0;
      wr_q     <= '0;
      wd_q     <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      regwr_q  <= grant_a || grant_m;
      if (grant_a) begin
        wr_q <= sa_addr;
        wd_q <= sa_data;
      end else if (grant_m) begin
        wr_q <= sm_addr;
        wd_q <= sm_data;
      end
    end
  end

  assign regwr = regwr_q;
  assign wr    = wr_q;
  assign wd    = wd_q;

  function automatic logic addr_hit(input logic [AW-1:0] a,
                                    input logic [AW-1:0] r1,
                                    input logic [AW-1:0] r2);
`ifdef RF_ZERO_REG_GUARD_EN
    return ((r1 != '0) && (a == r1)) || ((r2 != '0) && (a == r2));
`else
    return (a == r1) || (a == r2);
`endif
  endfunction

  // Covers both queued slots and the write currently on the RF port (commits next edge).
  assign hazard = (sa_valid && addr_hit(sa_addr, rr1, rr2)) ||
                  (sm_valid && addr_hit(sm_addr, rr1, rr2)) ||
                  (regwr_q  && addr_hit(wr_q, rr1, rr2));

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed self-checking bench for rf_wr_arbiter; honours RF_ZERO_REG_GUARD_EN for the guard step.
module tb_rf_wr_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst_n;
  logic          a_valid, m_valid;
  logic          a_ready, m_ready;
  logic [AW-1:0] a_addr, m_addr;
  logic [DW-1:0] a_data, m_data;
  logic [AW-1:0] wr;
  logic [DW-1:0] wd;
  logic          regwr;
  logic [AW-1:0] rr1, rr2;
  logic          hazard;

  int compared   = 0;
  int mismatched = 0;

  rf_wr_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .a_addr  (a_addr),
    .a_data  (a_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_addr  (m_addr),
    .m_data  (m_data),
    .wr      (wr),
    .wd      (wd),
    .regwr   (regwr),
    .rr1     (rr1),
    .rr2     (rr2),
    .hazard  (hazard)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_issue(input string tag, input logic [AW-1:0] exp_wr,
                             input logic [DW-1:0] exp_wd);
    check({tag, "_regwr"}, {31'd0, regwr}, 32'd1);
    check({tag, "_wr"}, {27'd0, wr}, {27'd0, exp_wr});
    check({tag, "_wd"}, wd, exp_wd);
  endtask

  initial begin
    rst_n = 1'b0; a_valid = 1'b0; m_valid = 1'b0;
    a_addr = '0; a_data = '0; m_addr = '0; m_data = '0;
    rr1 = '0; rr2 = '0;
    #1;

    // Reset with a pending ALU request that must be dropped
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h99;
    step(); step();
    check("rst_regwr", {31'd0, regwr}, 32'd0);
    check("rst_wr", {27'd0, wr}, 32'd0);
    check("rst_wd", wd, 32'd0);
    check("rst_a_ready", {31'd0, a_ready}, 32'd1);
    check("rst_m_ready", {31'd0, m_ready}, 32'd1);
    rst_n = 1'b1; a_valid = 1'b0;
    step();
    check("post_rst_no_issue", {31'd0, regwr}, 32'd0);

    // Contention with rr_ptr at A: A issues first, M waits one cycle
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'hAAAA;
    m_valid = 1'b1; m_addr = 5'd5; m_data = 32'hBBBB;
    check("c1_a_ready", {31'd0, a_ready}, 32'd1);
    check("c1_m_ready", {31'd0, m_ready}, 32'd1);
    step();
    a_valid = 1'b0; m_valid = 1'b0;
    check("c1_no_issue_yet", {31'd0, regwr}, 32'd0);
    check("c1_m_blocked", {31'd0, m_ready}, 32'd0);
    check("c1_a_free", {31'd0, a_ready}, 32'd1);
    step();
    check_issue("c1_first", 5'd3, 32'hAAAA);
    check("c1_m_ready_back", {31'd0, m_ready}, 32'd1);
    step();
    check_issue("c1_second", 5'd5, 32'hBBBB);
    step();
    check("c1_idle", {31'd0, regwr}, 32'd0);
    check("c1_wd_hold", wd, 32'hBBBB);

    // Single ALU write; leaves rr_ptr pointing at M
    a_valid = 1'b1; a_addr = 5'd4; a_data = 32'h0123; rr1 = 5'd4; rr2 = 5'd31;
    check("s_hazard_before", {31'd0, hazard}, 32'd0);
    step();
    a_valid = 1'b0;
    check("s_latency", {31'd0, regwr}, 32'd0);
    check("s_hazard_slot", {31'd0, hazard}, 32'd1);
    step();
    check_issue("s_issue", 5'd4, 32'h0123);
    check("s_hazard_issue", {31'd0, hazard}, 32'd1);
    step();
    check("s_done", {31'd0, regwr}, 32'd0);
    check("s_hazard_clear", {31'd0, hazard}, 32'd0);

    // Contention repeated with rr_ptr at M: M issues first
    rr1 = 5'd0; rr2 = 5'd0;
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'hCCCC;
    m_valid = 1'b1; m_addr = 5'd5; m_data = 32'hDDDD;
    step();
    a_valid = 1'b0; m_valid = 1'b0;
    check("c2_a_blocked", {31'd0, a_ready}, 32'd0);
    check("c2_m_free", {31'd0, m_ready}, 32'd1);
    step();
    check_issue("c2_first", 5'd5, 32'hDDDD);
    step();
    check_issue("c2_second", 5'd3, 32'hCCCC);
    step();
    check("c2_idle", {31'd0, regwr}, 32'd0);

    // Back-to-back ALU stream to regs 1..8
    for (int i = 1; i <= 8; i++) begin
      a_valid = 1'b1; a_addr = AW'(i); a_data = 32'h100 + 32'(i);
      check("st_a_ready", {31'd0, a_ready}, 32'd1);
      step();
      if (i > 1) check_issue("st_issue", AW'(i - 1), 32'h100 + 32'(i - 1));
    end
    a_valid = 1'b0;
    step();
    check_issue("st_last", 5'd8, 32'h108);
    step();
    check("st_idle", {31'd0, regwr}, 32'd0);

    // Single load write; moves rr_ptr back to A
    m_valid = 1'b1; m_addr = 5'd9; m_data = 32'h55;
    step();
    m_valid = 1'b0;
    step();
    check_issue("m_issue", 5'd9, 32'h55);
    step();

    // Same-address race: A then M, M's value is the last on the port
    rr1 = 5'd7; rr2 = 5'd31;
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h1;
    m_valid = 1'b1; m_addr = 5'd7; m_data = 32'h2;
    step();
    a_valid = 1'b0; m_valid = 1'b0;
    check("r_hazard_slots", {31'd0, hazard}, 32'd1);
    step();
    check_issue("r_first", 5'd7, 32'h1);
    check("r_hazard_mid", {31'd0, hazard}, 32'd1);
    step();
    check_issue("r_last", 5'd7, 32'h2);
    check("r_hazard_last", {31'd0, hazard}, 32'd1);
    step();
    check("r_idle", {31'd0, regwr}, 32'd0);
    check("r_hazard_clear", {31'd0, hazard}, 32'd0);
    check("r_wr_hold", {27'd0, wr}, 32'd7);

    // Register 0 write
    rr1 = 5'd0; rr2 = 5'd0;
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hDEAD;
    check("z_a_ready", {31'd0, a_ready}, 32'd1);
    step();
    a_valid = 1'b0;
    check("z_latency", {31'd0, regwr}, 32'd0);
`ifdef RF_ZERO_REG_GUARD_EN
    check("z_hazard", {31'd0, hazard}, 32'd0);
    step();
    check("z_dropped", {31'd0, regwr}, 32'd0);
    check("z_wr_hold", {27'd0, wr}, 32'd7);
`else
    check("z_hazard", {31'd0, hazard}, 32'd1);
    step();
    check_issue("z_issue", 5'd0, 32'hDEAD);
`endif
    step();
    check("z_idle", {31'd0, regwr}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
